// File: rtl/wei_buf_pkg.sv
// Shared types and default widths for the weight buffer.
// With WEI_BUF_PARITY_EN defined, every stored word carries one even-parity bit.
package wei_buf_pkg;

  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_WEI_ADDR_WIDTH = 8;

`ifdef WEI_BUF_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    SERVE = 2'd2
  } wei_state_e;

endpackage

// File: rtl/wei_buf_if.sv
// Handshake bundle between the weight buffer and its neighbours
// (top control, global buffer fill stream, weight cache read port).
interface wei_buf_if
  import wei_buf_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int WEI_ADDR_WIDTH = DEF_WEI_ADDR_WIDTH
);

  logic                      TOPWBF_CfgVld;
  logic [WEI_ADDR_WIDTH:0]   TOPWBF_CfgNum;
  logic                      WBFTOP_CfgRdy;

  logic                      GLBWBF_DatVld;
  logic [DATA_WIDTH-1:0]     GLBWBF_Dat;
  logic                      WBFGLB_DatRdy;

  logic                      WCAWBF_AdrVld;
  logic [WEI_ADDR_WIDTH-1:0] WCAWBF_Adr;
  logic                      WBFWCA_AdrRdy;

  logic                      WBFWCA_DatVld;
  logic [DATA_WIDTH-1:0]     WBFWCA_Dat;
  logic                      WCAWBF_DatRdy;

  modport slave (
    input  TOPWBF_CfgVld, TOPWBF_CfgNum,
    output WBFTOP_CfgRdy,
    input  GLBWBF_DatVld, GLBWBF_Dat,
    output WBFGLB_DatRdy,
    input  WCAWBF_AdrVld, WCAWBF_Adr,
    output WBFWCA_AdrRdy,
    output WBFWCA_DatVld, WBFWCA_Dat,
    input  WCAWBF_DatRdy
  );

  modport master (
    output TOPWBF_CfgVld, TOPWBF_CfgNum,
    input  WBFTOP_CfgRdy,
    output GLBWBF_DatVld, GLBWBF_Dat,
    input  WBFGLB_DatRdy,
    output WCAWBF_AdrVld, WCAWBF_Adr,
    input  WBFWCA_AdrRdy,
    input  WBFWCA_DatVld, WBFWCA_Dat,
    output WCAWBF_DatRdy
  );

endinterface

// File: rtl/wei_buf_ram.sv
// Simple dual-port storage: one write port, one read port with registered output.
// Contents are deliberately not reset; the read register holds until the next read.
module wei_buf_ram #(
  parameter int WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/wei_buf.sv
// Weight buffer: loads a configured number of words from the global buffer,
// then serves single-outstanding reads to the weight cache. Optional: WEI_BUF_PARITY_EN.
module wei_buf
  import wei_buf_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int WEI_ADDR_WIDTH = DEF_WEI_ADDR_WIDTH
) (
  input  logic     clk,
  input  logic     rst_n,
  wei_buf_if.slave bus,
  output logic     WBFTOP_Loaded
`ifdef WEI_BUF_PARITY_EN
  ,
  output logic     WBFTOP_ParErr
`endif
);

  localparam int NUM_WIDTH = WEI_ADDR_WIDTH + 1;
  localparam int RAM_WIDTH = DATA_WIDTH + PAR_BITS;

  wei_state_e                state_reg, state_next;
  logic [NUM_WIDTH-1:0]      num_reg, num_next;
  logic [WEI_ADDR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;

  logic rsp_vld_reg, rsp_vld_next;
  logic in_range_reg, in_range_next;
  logic first_reg, first_next;

  logic cfg_rdy, fill_rdy, adr_rdy, loaded;
  logic cfg_fire, fill_fire, adr_fire, last_word;

  logic [RAM_WIDTH-1:0] ram_wdata, ram_rdata;

  // Wrap-around of wr_ptr makes num == DEPTH end exactly on the last entry.
  assign last_word = ({1'b0, wr_ptr_reg} == (num_reg - NUM_WIDTH'(1)));

  always_comb begin
    state_next  = state_reg;
    num_next    = num_reg;
    wr_ptr_next = wr_ptr_reg;
    cfg_rdy     = 1'b0;
    fill_rdy    = 1'b0;
    adr_rdy     = 1'b0;
    loaded      = 1'b0;

    case (state_reg)
      IDLE: begin
        cfg_rdy = 1'b1;
      end
      FILL: begin
        fill_rdy = 1'b1;
      end
      SERVE: begin
        cfg_rdy = !rsp_vld_reg;
        adr_rdy = !rsp_vld_reg || bus.WCAWBF_DatRdy;
        loaded  = 1'b1;
      end
      default: begin
        cfg_rdy = 1'b0;
      end
    endcase

    cfg_fire  = bus.TOPWBF_CfgVld && cfg_rdy;
    fill_fire = bus.GLBWBF_DatVld && fill_rdy;
    adr_fire  = bus.WCAWBF_AdrVld && adr_rdy;

    case (state_reg)
      IDLE, SERVE: begin
        if (cfg_fire) begin
          num_next    = bus.TOPWBF_CfgNum;
          wr_ptr_next = '0;
          state_next  = (bus.TOPWBF_CfgNum == '0) ? SERVE : FILL;
        end
      end
      FILL: begin
        if (fill_fire) begin
          wr_ptr_next = wr_ptr_reg + WEI_ADDR_WIDTH'(1);
          if (last_word) begin
            state_next = SERVE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Response slot: a new address may replace the held word only as it drains.
  always_comb begin
    rsp_vld_next  = rsp_vld_reg;
    in_range_next = in_range_reg;
    first_next    = 1'b0;
    if (adr_fire) begin
      rsp_vld_next  = 1'b1;
      in_range_next = ({1'b0, bus.WCAWBF_Adr} < num_reg);
      first_next    = 1'b1;
    end else if (bus.WCAWBF_DatRdy) begin
      rsp_vld_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      num_reg      <= '0;
      wr_ptr_reg   <= '0;
      rsp_vld_reg  <= 1'b0;
      in_range_reg <= 1'b0;
      first_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      num_reg      <= num_next;
      wr_ptr_reg   <= wr_ptr_next;
      rsp_vld_reg  <= rsp_vld_next;
      in_range_reg <= in_range_next;
      first_reg    <= first_next;
    end
  end

`ifdef WEI_BUF_PARITY_EN
  assign ram_wdata = {^bus.GLBWBF_Dat, bus.GLBWBF_Dat};
`else
  assign ram_wdata = bus.GLBWBF_Dat;
`endif

  wei_buf_ram #(
    .WIDTH      (RAM_WIDTH),
    .ADDR_WIDTH (WEI_ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (fill_fire),
    .waddr (wr_ptr_reg),
    .wdata (ram_wdata),
    .re    (adr_fire),
    .raddr (bus.WCAWBF_Adr),
    .rdata (ram_rdata)
  );

  // Out-of-range and reset-cleared slots read as zero, hiding stale RAM words.
  assign bus.WBFWCA_Dat    = (rsp_vld_reg && in_range_reg) ? ram_rdata[DATA_WIDTH-1:0] : '0;
  assign bus.WBFWCA_DatVld = rsp_vld_reg;
  assign bus.WBFWCA_AdrRdy = adr_rdy;
  assign bus.WBFGLB_DatRdy = fill_rdy;
  assign bus.WBFTOP_CfgRdy = cfg_rdy;
  assign WBFTOP_Loaded     = loaded;

`ifdef WEI_BUF_PARITY_EN
  assign WBFTOP_ParErr = first_reg && rsp_vld_reg && in_range_reg && (^ram_rdata);
`endif

endmodule

// File: tb/tb_wei_buf.sv
// Directed bench for wei_buf with a cycle-level behavioural model compared at every negedge.
// Build with WEI_BUF_PARITY_EN to add the parity-corruption scenario.
module tb_wei_buf;

  localparam int DEPTH = 256;
  localparam int M_IDLE = 0, M_FILL = 1, M_SERVE = 2;

  logic clk;
  logic rst_n;
  logic loaded;
`ifdef WEI_BUF_PARITY_EN
  logic par_err;
`endif

  int checks = 0;
  int passes = 0;

  wei_buf_if bus ();

  wei_buf dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .WBFTOP_Loaded (loaded)
`ifdef WEI_BUF_PARITY_EN
    ,
    .WBFTOP_ParErr (par_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: words are addressed by fill order, num bounds the readable range.
  logic [7:0] m_mem [DEPTH];
  bit         m_corrupt [DEPTH];
  int         m_state, m_num, m_filled;
  bit         m_vld, m_first, m_perr;
  logic [7:0] m_dat;

  initial begin
    bit e_cfg, e_fill, e_adr;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = 8'h00;
      m_corrupt[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_state = M_IDLE; m_num = 0; m_filled = 0;
        m_vld = 0; m_first = 0; m_perr = 0; m_dat = 8'h00;
        check("rst_dat", 32'(bus.WBFWCA_Dat), 32'h0);
      end
      e_cfg  = (m_state == M_IDLE) || (m_state == M_SERVE && !m_vld);
      e_fill = (m_state == M_FILL);
      e_adr  = (m_state == M_SERVE) && (!m_vld || bus.WCAWBF_DatRdy);
      check("cfg_rdy", 32'(bus.WBFTOP_CfgRdy), 32'(e_cfg));
      check("glb_rdy", 32'(bus.WBFGLB_DatRdy), 32'(e_fill));
      check("adr_rdy", 32'(bus.WBFWCA_AdrRdy), 32'(e_adr));
      check("loaded",  32'(loaded), 32'(m_state == M_SERVE));
      check("dat_vld", 32'(bus.WBFWCA_DatVld), 32'(m_vld));
      if (m_vld) check("rsp_dat", 32'(bus.WBFWCA_Dat), 32'(m_dat));
`ifdef WEI_BUF_PARITY_EN
      check("par_err", 32'(par_err), 32'(m_first && m_perr));
`endif
      if (rst_n) begin
        m_first = 0;
        if (bus.WCAWBF_AdrVld && e_adr) begin
          m_vld = 1; m_first = 1;
          if (int'(bus.WCAWBF_Adr) < m_num) begin
            m_dat  = m_mem[bus.WCAWBF_Adr];
            m_perr = m_corrupt[bus.WCAWBF_Adr];
          end else begin
            m_dat = 8'h00; m_perr = 0;
          end
        end else if (bus.WCAWBF_DatRdy) begin
          m_vld = 0;
        end
        if (bus.TOPWBF_CfgVld && e_cfg) begin
          m_num = int'(bus.TOPWBF_CfgNum);
          m_filled = 0;
          m_state = (m_num == 0) ? M_SERVE : M_FILL;
        end else if (bus.GLBWBF_DatVld && e_fill) begin
          m_mem[m_filled % DEPTH] = bus.GLBWBF_Dat;
          m_corrupt[m_filled % DEPTH] = 1'b0;
          m_filled++;
          if (m_filled == m_num) m_state = M_SERVE;
        end
      end
    end
  end

  task automatic config_num(input int n);
    bus.TOPWBF_CfgVld = 1'b1;
    bus.TOPWBF_CfgNum = 9'(n);
    tick();
    bus.TOPWBF_CfgVld = 1'b0;
  endtask

  task automatic fill_word(input logic [7:0] w);
    bus.GLBWBF_DatVld = 1'b1;
    bus.GLBWBF_Dat    = w;
    tick();
    bus.GLBWBF_DatVld = 1'b0;
  endtask

  task automatic read_check(input logic [7:0] a, input logic [7:0] exp, input string name);
    bus.WCAWBF_AdrVld = 1'b1;
    bus.WCAWBF_Adr    = a;
    bus.WCAWBF_DatRdy = 1'b1;
    tick();
    check({name, "_vld"}, 32'(bus.WBFWCA_DatVld), 32'h1);
    check(name, 32'(bus.WBFWCA_Dat), 32'(exp));
  endtask

  task automatic drain();
    bus.WCAWBF_AdrVld = 1'b0;
    bus.WCAWBF_DatRdy = 1'b1;
    tick();
    check("drain_vld", 32'(bus.WBFWCA_DatVld), 32'h0);
  endtask

  initial begin
    logic [7:0] words [4];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;

    rst_n = 1'b0;
    bus.TOPWBF_CfgVld = 1'b0; bus.TOPWBF_CfgNum = '0;
    bus.GLBWBF_DatVld = 1'b0; bus.GLBWBF_Dat = '0;
    bus.WCAWBF_AdrVld = 1'b0; bus.WCAWBF_Adr = '0;
    bus.WCAWBF_DatRdy = 1'b0;
    #1;
    check("reset_cfg_rdy", 32'(bus.WBFTOP_CfgRdy), 32'h1);
    check("reset_loaded", 32'(loaded), 32'h0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic load of four words then back-to-back reads.
    config_num(4);
    check("fill_rdy", 32'(bus.WBFGLB_DatRdy), 32'h1);
    for (int i = 0; i < 4; i++) begin
      check("loaded_during_fill", 32'(loaded), 32'h0);
      fill_word(words[i]);
    end
    check("loaded_after_fill", 32'(loaded), 32'h1);
    for (int i = 0; i < 4; i++) read_check(8'(i), words[i], "b2b_read");
    drain();

    // Backpressured response on address 2 stays put.
    bus.WCAWBF_AdrVld = 1'b1; bus.WCAWBF_Adr = 8'd2; bus.WCAWBF_DatRdy = 1'b0;
    tick();
    bus.WCAWBF_Adr = 8'd3;
    for (int i = 0; i < 3; i++) begin
      check("hold_vld", 32'(bus.WBFWCA_DatVld), 32'h1);
      check("hold_dat", 32'(bus.WBFWCA_Dat), 32'h33);
      check("hold_adr_rdy", 32'(bus.WBFWCA_AdrRdy), 32'h0);
      tick();
    end
    drain();

    // Out-of-range address reads zero.
    read_check(8'd200, 8'h00, "oor_read");
    drain();

    // Empty configuration: straight to SERVE, no fill accepted.
    bus.GLBWBF_DatVld = 1'b1; bus.GLBWBF_Dat = 8'h99;
    config_num(0);
    check("num0_loaded", 32'(loaded), 32'h1);
    check("num0_glb_rdy", 32'(bus.WBFGLB_DatRdy), 32'h0);
    read_check(8'd0, 8'h00, "num0_read0");
    read_check(8'd1, 8'h00, "num0_read1");
    bus.GLBWBF_DatVld = 1'b0;
    drain();

    // Reset in the middle of a fill, then refill with two new words.
    config_num(4);
    fill_word(8'hA1);
    fill_word(8'hA2);
    rst_n = 1'b0;
    #1;
    check("midfill_cfg_rdy", 32'(bus.WBFTOP_CfgRdy), 32'h1);
    check("midfill_vld", 32'(bus.WBFWCA_DatVld), 32'h0);
    check("midfill_loaded", 32'(loaded), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    config_num(2);
    fill_word(8'h5A);
    fill_word(8'hA5);
    read_check(8'd0, 8'h5A, "refill_read0");
    read_check(8'd1, 8'hA5, "refill_read1");
    read_check(8'd2, 8'h00, "refill_stale");
    drain();

`ifdef WEI_BUF_PARITY_EN
    // Corrupt one data bit of word 1 behind the parity bit's back.
    dut.u_ram.mem[1] = dut.u_ram.mem[1] ^ 9'h001;
    m_mem[1] = m_mem[1] ^ 8'h01;
    m_corrupt[1] = 1'b1;
    bus.WCAWBF_AdrVld = 1'b1; bus.WCAWBF_Adr = 8'd1; bus.WCAWBF_DatRdy = 1'b0;
    tick();
    bus.WCAWBF_AdrVld = 1'b0;
    check("par_err_first", 32'(par_err), 32'h1);
    check("par_err_vld", 32'(bus.WBFWCA_DatVld), 32'h1);
    tick();
    check("par_err_second", 32'(par_err), 32'h0);
    drain();
`endif

    // Reset with a response in flight drops it.
    bus.WCAWBF_AdrVld = 1'b1; bus.WCAWBF_Adr = 8'd0; bus.WCAWBF_DatRdy = 1'b0;
    tick();
    bus.WCAWBF_AdrVld = 1'b0;
    check("inflight_vld", 32'(bus.WBFWCA_DatVld), 32'h1);
    rst_n = 1'b0;
    #1;
    check("inflight_dropped", 32'(bus.WBFWCA_DatVld), 32'h0);
    check("inflight_dat", 32'(bus.WBFWCA_Dat), 32'h0);
    tick();
    rst_n = 1'b1;
    bus.WCAWBF_AdrVld = 1'b1;
    tick(); tick();
    check("post_reset_vld", 32'(bus.WBFWCA_DatVld), 32'h0);
    bus.WCAWBF_AdrVld = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wei_buf.md
WEI_BUF -- requirements
Module: wei_buf

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, weight word width.
REQ-002 SHALL have parameter WEI_ADDR_WIDTH, default 8, weight address width; depth DEPTH = 2**WEI_ADDR_WIDTH.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports TOPWBF_CfgVld input 1, TOPWBF_CfgNum input WEI_ADDR_WIDTH+1, WBFTOP_CfgRdy output 1: load-length configuration handshake.
REQ-006 SHALL have ports GLBWBF_DatVld input 1, GLBWBF_Dat input DATA_WIDTH, WBFGLB_DatRdy output 1: weight fill stream from global buffer.
REQ-007 SHALL have ports WCAWBF_AdrVld input 1, WCAWBF_Adr input WEI_ADDR_WIDTH, WBFWCA_AdrRdy output 1: read-address request from weight cache.
REQ-008 SHALL have ports WBFWCA_DatVld output 1, WBFWCA_Dat output DATA_WIDTH, WCAWBF_DatRdy input 1: read-data response to weight cache.
REQ-009 SHALL have port WBFTOP_Loaded  output 1  high while in SERVE.

Function
REQ-010 SHALL implement FSM states IDLE, FILL, SERVE; a handshake completes when Vld & Rdy in the same cycle.
REQ-011 SHALL drive WBFTOP_CfgRdy = (IDLE) | (SERVE & !WBFWCA_DatVld).
REQ-012 SHALL on config handshake latch num = TOPWBF_CfgNum, clear wr_ptr, go to FILL; if num == 0 go directly to SERVE.
REQ-013 SHALL in FILL drive WBFGLB_DatRdy = 1 and write each accepted word to mem[wr_ptr], wr_ptr += 1.
REQ-014 SHALL transition FILL -> SERVE in the cycle the word with wr_ptr == num-1 is accepted; num == DEPTH fills all entries (wr_ptr wraps to 0, no extra write).
REQ-015 SHALL drive WBFGLB_DatRdy = 0 outside FILL; excess fill words are not accepted.
REQ-016 SHALL drive WBFWCA_AdrRdy = SERVE & (!WBFWCA_DatVld | WCAWBF_DatRdy).
REQ-017 SHALL present read data exactly 1 cycle after address handshake in an output register, WBFWCA_DatVld = 1.
REQ-018 SHALL hold WBFWCA_Dat/WBFWCA_DatVld stable until WCAWBF_DatRdy; back-to-back addresses with DatRdy held high give one word per cycle.
REQ-019 SHALL return 0 (with DatVld = 1) for any address >= num.
REQ-020 SHALL preserve request order; at most one response outstanding.
REQ-021 SHALL in SERVE on a new config handshake go to FILL and overwrite from address 0; prior contents beyond new num read as 0.
REQ-022 SHALL ignore TOPWBF_CfgVld while in FILL (CfgRdy = 0).

Reset
REQ-023 SHALL on rst_n low asynchronously set state = IDLE, num = 0, wr_ptr = 0, WBFWCA_DatVld = 0, WBFWCA_Dat = 0, WBFTOP_Loaded = 0, WBFGLB_DatRdy = 0, WBFWCA_AdrRdy = 0, WBFTOP_CfgRdy = 1 after deassertion.
REQ-024 SHALL not reset mem contents; REQ-019 masks stale data.
REQ-025 SHALL on reset mid-FILL or mid-SERVE drop the in-flight response; nothing is emitted after reset until a new config.

Configuration
REQ-026 SHALL, with WEI_BUF_PARITY_EN defined, store an even-parity bit per word, check it on read, and drive output WBFTOP_ParErr (1 bit) high for one cycle aligned with the first cycle of the erroneous response; reset value 0.
REQ-027 SHALL, without WEI_BUF_PARITY_EN, omit the parity bit storage and the WBFTOP_ParErr port.

Structure
REQ-028 SHALL place the FSM state enum (IDLE/FILL/SERVE) and default widths in shared package wei_buf_pkg.
REQ-029 SHALL instantiate one sub-module wei_buf_ram (1W1R synchronous RAM, 1-cycle read latency, DEPTH x (DATA_WIDTH+parity)).

Verification
REQ-030 SHALL cover: config num=4, fill 0x11,0x22,0x33,0x44 -> Loaded=1 after 4th handshake; reads 0..3 with DatRdy=1 -> 0x11,0x22,0x33,0x44 on consecutive cycles.
REQ-031 SHALL cover: read addr 2 with DatRdy=0 for 3 cycles -> DatVld=1, Dat=0x33 stable, AdrRdy=0 until DatRdy=1.
REQ-032 SHALL cover: num=4 loaded, read addr 200 -> Dat=0x00, DatVld=1 one cycle later.
REQ-033 SHALL cover: num=0 config -> SERVE next cycle, no GLB words accepted, any read returns 0.
REQ-034 SHALL cover: rst_n pulsed low during FILL after 2 words -> state IDLE, CfgRdy=1, DatVld=0; re-fill num=2 reads back new data.
REQ-035 SHALL cover (WEI_BUF_PARITY_EN): force flipped bit in word at addr 1 -> read addr 1 gives ParErr=1 for one cycle with DatVld=1.
